// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared widths, write-request struct and slice helper for the register file write path
// Requester buses are flattened, so the slice helper takes a fixed maximum width and the caller zero-extends.
package rf_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  localparam int RF_DEPTH  = 32;
  localparam int MAX_REQ   = 8;
  localparam int REQ_IDX_W = 3;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } rf_wr_t;

  // Constant-base slices keep the select widths exact for any legal index.
  function automatic rf_wr_t req_slice(
    input logic [RF_ADDR_W*MAX_REQ-1:0] addr_flat,
    input logic [RF_DATA_W*MAX_REQ-1:0] data_flat,
    input logic [REQ_IDX_W-1:0]         idx
  );
    rf_wr_t r;
    r = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (idx == REQ_IDX_W'(k)) begin
        r.addr = addr_flat[k*RF_ADDR_W +: RF_ADDR_W];
        r.data = data_flat[k*RF_DATA_W +: RF_DATA_W];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin search starting one past the last winner
// The pointer register lives in the caller; this block only finds the next set request.
module rr_arbiter #(
  parameter int N = 2,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [IDX_W-1:0] cand;

  // Offsets 1..N visit every requester once, ending on the last winner itself.
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int off = 1; off <= N; off++) begin
      cand = IDX_W'((int'(last) + off) % N);
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - round-robin sharing of the register file write port among NREQ requesters
// Grant is combinational; the winning write is registered onto inW1/inD1/inWe one cycle later.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter bit DROP_R0 = 1'b1
) (
  input  logic                      inClk,
  input  logic                      inArstn,
  input  logic                      inStall,
  input  logic [NREQ-1:0]           inReqValid,
  input  logic [NREQ*RF_ADDR_W-1:0] inReqAddr,
  input  logic [NREQ*RF_DATA_W-1:0] inReqData,
  output logic [NREQ-1:0]           outReqReady,
  output logic [RF_ADDR_W-1:0]      outW1,
  output logic [RF_DATA_W-1:0]      outD1,
  output logic                      outWe
);

  localparam int IDX_W = $clog2(NREQ);

  logic [IDX_W-1:0]             last_gnt;
  logic [IDX_W-1:0]             gnt_idx;
  logic [NREQ-1:0]              gnt_onehot;
  logic                         gnt_any;
  logic                         grant_en;
  logic                         xfer;
  logic [RF_ADDR_W*MAX_REQ-1:0] addr_flat;
  logic [RF_DATA_W*MAX_REQ-1:0] data_flat;
  rf_wr_t                       win;

  rr_arbiter #(
    .N(NREQ)
  ) u_rr (
    .req  (inReqValid),
    .last (last_gnt),
    .grant(gnt_onehot),
    .idx  (gnt_idx),
    .valid(gnt_any)
  );

  // Ready is a function of valids, stall and the pointer only, never of the payload.
  assign grant_en    = inArstn & ~inStall;
  assign outReqReady = grant_en ? gnt_onehot : '0;
  assign xfer        = |(inReqValid & outReqReady);

  assign addr_flat = (RF_ADDR_W*MAX_REQ)'(inReqAddr);
  assign data_flat = (RF_DATA_W*MAX_REQ)'(inReqData);
  assign win       = req_slice(addr_flat, data_flat, REQ_IDX_W'(gnt_idx));

  always_ff @(posedge inClk) begin
    if (!inArstn) begin
      last_gnt <= IDX_W'(NREQ - 1);
      outWe    <= 1'b0;
      outW1    <= '0;
      outD1    <= '0;
    end else if (xfer) begin
      last_gnt <= gnt_idx;
      outW1    <= win.addr;
      outD1    <= win.data;
      // A write to r0 is still consumed so the requester moves on.
      outWe    <= ~(DROP_R0 & (win.addr == '0));
    end else begin
      outWe <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - self-checking bench for rf_write_arbiter against a round-robin reference model
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        arstn = 1'b0;
  logic        stall = 1'b0;
  logic        stall3 = 1'b0;
  logic [1:0]  valid2 = '0;
  logic [2:0]  valid3 = '0;
  logic [4:0]  addr2 [2];
  logic [31:0] data2 [2];
  logic [4:0]  addr3 [3];
  logic [31:0] data3 [3];
  logic [9:0]  addr2_flat;
  logic [63:0] data2_flat;
  logic [14:0] addr3_flat;
  logic [95:0] data3_flat;

  logic [1:0]  rdy2, rdy_nd;
  logic [2:0]  rdy3;
  logic [4:0]  w1_2, w1_nd, w1_3;
  logic [31:0] d1_2, d1_nd, d1_3;
  logic        we_2, we_nd, we_3;

  logic [31:0] rf [32];

  int errors = 0;
  int checks = 0;

  int          m2_ptr, m3_ptr;
  logic        m2_we, mnd_we, m3_we;
  logic [4:0]  m2_w1, m3_w1;
  logic [31:0] m2_d1, m3_d1;

  assign addr2_flat = {addr2[1], addr2[0]};
  assign data2_flat = {data2[1], data2[0]};
  assign addr3_flat = {addr3[2], addr3[1], addr3[0]};
  assign data3_flat = {data3[2], data3[1], data3[0]};

  always #5 clk = ~clk;

  rf_write_arbiter #(.NREQ(2), .DROP_R0(1'b1)) dut (
    .inClk(clk), .inArstn(arstn), .inStall(stall), .inReqValid(valid2),
    .inReqAddr(addr2_flat), .inReqData(data2_flat), .outReqReady(rdy2),
    .outW1(w1_2), .outD1(d1_2), .outWe(we_2)
  );

  rf_write_arbiter #(.NREQ(2), .DROP_R0(1'b0)) dut_nd (
    .inClk(clk), .inArstn(arstn), .inStall(stall), .inReqValid(valid2),
    .inReqAddr(addr2_flat), .inReqData(data2_flat), .outReqReady(rdy_nd),
    .outW1(w1_nd), .outD1(d1_nd), .outWe(we_nd)
  );

  rf_write_arbiter #(.NREQ(3), .DROP_R0(1'b1)) dut3 (
    .inClk(clk), .inArstn(arstn), .inStall(stall3), .inReqValid(valid3),
    .inReqAddr(addr3_flat), .inReqData(data3_flat), .outReqReady(rdy3),
    .outW1(w1_3), .outD1(d1_3), .outWe(we_3)
  );

  // Register file downstream of the main instance: captures on the edge after outWe rises.
  always @(posedge clk) if (we_2) rf[w1_2] <= d1_2;

  // Reference: walk the requesters in rotated order after the last winner.
  function automatic int winner(input logic [7:0] v, input int ptr, input int n,
                                input logic rst_n, input logic st);
    if (!rst_n || st) return -1;
    for (int k = 1; k <= n; k++) begin
      if (v[(ptr + k) % n]) return (ptr + k) % n;
    end
    return -1;
  endfunction

  function automatic logic [7:0] onehot(input int w);
    return (w < 0) ? 8'd0 : (8'd1 << w);
  endfunction

  task automatic tick();
    int w2, w3;
    w2 = winner({6'd0, valid2}, m2_ptr, 2, arstn, stall);
    w3 = winner({5'd0, valid3}, m3_ptr, 3, arstn, stall3);
    @(posedge clk);
    if (!arstn) begin
      m2_ptr = 1; m2_we = 0; mnd_we = 0; m2_w1 = 0; m2_d1 = 0;
      m3_ptr = 2; m3_we = 0; m3_w1 = 0; m3_d1 = 0;
    end else begin
      if (w2 >= 0) begin
        m2_ptr = w2; m2_w1 = addr2[w2]; m2_d1 = data2[w2];
        m2_we = (addr2[w2] != 5'd0); mnd_we = 1'b1;
      end else begin
        m2_we = 1'b0; mnd_we = 1'b0;
      end
      if (w3 >= 0) begin
        m3_ptr = w3; m3_w1 = addr3[w3]; m3_d1 = data3[w3];
        m3_we = (addr3[w3] != 5'd0);
      end else begin
        m3_we = 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] e;
    arstn = 0; stall = 0; valid2 = 2'b11; valid3 = 3'b111;
    addr2[0] = 5'd3; data2[0] = 32'h1111_0003;
    addr2[1] = 5'd4; data2[1] = 32'h2222_0004;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (rdy2 !== 2'b00 || rdy3 !== 3'b000) begin
        errors++; $display("FAIL reset_ready cyc%0d: got %b/%b want 00/000", i, rdy2, rdy3);
      end
      tick();
      checks++;
      if (we_2 !== 1'b0 || w1_2 !== 5'd0 || d1_2 !== 32'd0 || we_3 !== 1'b0) begin
        errors++; $display("FAIL reset_outputs cyc%0d: got we=%b w1=%h d1=%h want 0 0 0", i, we_2, w1_2, d1_2);
      end
    end
    arstn = 1; valid3 = 3'b000;
    #1;
    e = onehot(winner({6'd0, valid2}, m2_ptr, 2, arstn, stall));
    checks++;
    if (rdy2 !== 2'b01 || rdy2 !== e[1:0]) begin
      errors++; $display("FAIL reset_first_grant: got %b want 01", rdy2);
    end
    tick();
    checks++;
    if (we_2 !== 1'b1 || w1_2 !== 5'd3 || d1_2 !== 32'h1111_0003) begin
      errors++; $display("FAIL reset_first_write: got we=%b w1=%h d1=%h want 1 03 11110003", we_2, w1_2, d1_2);
    end
    valid2 = 2'b00;
    tick();
  endtask

  task automatic test_single();
    valid2 = 2'b10; addr2[1] = 5'd7; data2[1] = 32'hbadb0007;
    #1;
    checks++;
    if (rdy2 !== 2'b10) begin
      errors++; $display("FAIL single_ready: got %b want 10", rdy2);
    end
    tick();
    checks++;
    if (we_2 !== 1'b1 || w1_2 !== 5'd7 || d1_2 !== 32'hbadb0007) begin
      errors++; $display("FAIL single_write: got we=%b w1=%h d1=%h want 1 07 badb0007", we_2, w1_2, d1_2);
    end
    valid2 = 2'b00;
    tick();
    checks++;
    if (rf[7] !== 32'hbadb0007 || we_2 !== 1'b0) begin
      errors++; $display("FAIL single_rf_read: got rf7=%h we=%b want badb0007 0", rf[7], we_2);
    end
  endtask

  task automatic test_contention();
    logic [1:0] exp_c;
    logic [7:0] e;
    int g;
    for (int r = 0; r < 2; r++) begin
      addr2[r] = 5'($urandom_range(1, 31)); data2[r] = $urandom;
    end
    valid2 = 2'b11;
    for (int i = 0; i < 6; i++) begin
      #1;
      exp_c = (i % 2 == 0) ? 2'b01 : 2'b10;
      e = onehot(winner({6'd0, valid2}, m2_ptr, 2, arstn, stall));
      checks++;
      if (rdy2 !== exp_c || rdy2 !== e[1:0]) begin
        errors++; $display("FAIL contention_grant cyc%0d: got %b want %b", i, rdy2, exp_c);
      end
      tick();
      checks++;
      if (we_2 !== 1'b1 || w1_2 !== m2_w1 || d1_2 !== m2_d1) begin
        errors++; $display("FAIL contention_write cyc%0d: got we=%b w1=%h d1=%h want 1 %h %h", i, we_2, w1_2, d1_2, m2_w1, m2_d1);
      end
      g = m2_ptr;
      addr2[g] = 5'($urandom_range(1, 31)); data2[g] = $urandom;
    end
  endtask

  task automatic test_stall();
    logic [4:0]  held_w1;
    logic [31:0] held_d1;
    held_w1 = m2_w1; held_d1 = m2_d1;
    valid2 = 2'b11; stall = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (rdy2 !== 2'b00) begin
        errors++; $display("FAIL stall_ready cyc%0d: got %b want 00", i, rdy2);
      end
      tick();
      checks++;
      if (we_2 !== 1'b0 || w1_2 !== held_w1 || d1_2 !== held_d1) begin
        errors++; $display("FAIL stall_hold cyc%0d: got we=%b w1=%h d1=%h want 0 %h %h", i, we_2, w1_2, d1_2, held_w1, held_d1);
      end
    end
    stall = 0;
    #1;
    checks++;
    if (rdy2 !== 2'b01) begin
      errors++; $display("FAIL stall_resume: got %b want 01", rdy2);
    end
    tick();
    checks++;
    if (we_2 !== m2_we || w1_2 !== m2_w1 || d1_2 !== m2_d1) begin
      errors++; $display("FAIL stall_resume_write: got we=%b w1=%h want %b %h", we_2, w1_2, m2_we, m2_w1);
    end
    valid2 = 2'b00;
    tick();
  endtask

  task automatic test_r0_drop();
    valid2 = 2'b01; addr2[0] = 5'd0; data2[0] = 32'hffffffff;
    #1;
    checks++;
    if (rdy2 !== 2'b01 || rdy_nd !== 2'b01) begin
      errors++; $display("FAIL r0_ready: got %b/%b want 01/01", rdy2, rdy_nd);
    end
    tick();
    checks++;
    if (we_2 !== 1'b0) begin
      errors++; $display("FAIL r0_drop_we: got %b want 0", we_2);
    end
    checks++;
    if (we_nd !== 1'b1 || w1_nd !== 5'd0 || d1_nd !== 32'hffffffff) begin
      errors++; $display("FAIL r0_keep_write: got we=%b w1=%h d1=%h want 1 00 ffffffff", we_nd, w1_nd, d1_nd);
    end
    valid2 = 2'b00;
    tick();
    checks++;
    if (rf[0] !== 32'd0) begin
      errors++; $display("FAIL r0_rf_unchanged: got %h want 00000000", rf[0]);
    end
  endtask

  task automatic test_reset_mid();
    for (int r = 0; r < 2; r++) begin
      addr2[r] = 5'($urandom_range(1, 31)); data2[r] = $urandom;
    end
    valid2 = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      addr2[m2_ptr] = 5'($urandom_range(1, 31)); data2[m2_ptr] = $urandom;
    end
    arstn = 0;
    #1;
    checks++;
    if (rdy2 !== 2'b00) begin
      errors++; $display("FAIL midreset_ready: got %b want 00", rdy2);
    end
    tick();
    checks++;
    if (we_2 !== 1'b0 || we_nd !== 1'b0) begin
      errors++; $display("FAIL midreset_we: got %b/%b want 0/0", we_2, we_nd);
    end
    arstn = 1;
    #1;
    checks++;
    if (rdy2 !== 2'b01) begin
      errors++; $display("FAIL midreset_first_grant: got %b want 01", rdy2);
    end
    tick();
    checks++;
    if (we_2 !== 1'b1 || w1_2 !== addr2[0] || d1_2 !== data2[0]) begin
      errors++; $display("FAIL midreset_write: got w1=%h d1=%h want %h %h", w1_2, d1_2, addr2[0], data2[0]);
    end
    valid2 = 2'b00;
    tick();
  endtask

  task automatic test_fairness();
    int cnt [3];
    logic [7:0] e;
    cnt = '{0, 0, 0};
    for (int r = 0; r < 3; r++) begin
      addr3[r] = 5'(r + 10); data3[r] = 32'hfa00_0000 + r;
    end
    valid3 = 3'b111; stall3 = 0;
    for (int i = 0; i < 9; i++) begin
      #1;
      e = onehot(winner({5'd0, valid3}, m3_ptr, 3, arstn, stall3));
      checks++;
      if (rdy3 !== e[2:0]) begin
        errors++; $display("FAIL fair_grant cyc%0d: got %b want %b", i, rdy3, e[2:0]);
      end
      for (int r = 0; r < 3; r++) if (rdy3[r]) cnt[r]++;
      tick();
    end
    for (int r = 0; r < 3; r++) begin
      checks++;
      if (cnt[r] != 3) begin
        errors++; $display("FAIL fair_count req%0d: got %0d want 3", r, cnt[r]);
      end
    end
    valid3 = 3'b000;
    tick();
  endtask

  task automatic test_random();
    logic [7:0] e;
    int w;
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < 3; r++) begin
        if (!valid3[r]) begin
          if ($urandom_range(0, 1) == 1) begin
            valid3[r] = 1'b1;
            addr3[r]  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            data3[r]  = $urandom;
          end
        end else if ($urandom_range(0, 19) == 0) begin
          valid3[r] = 1'b0;
        end
      end
      stall3 = ($urandom_range(0, 3) == 0);
      arstn  = ($urandom_range(0, 39) != 0);
      #1;
      w = winner({5'd0, valid3}, m3_ptr, 3, arstn, stall3);
      e = onehot(w);
      checks++;
      if (rdy3 !== e[2:0]) begin
        errors++; $display("FAIL rand_grant cyc%0d: got %b want %b", i, rdy3, e[2:0]);
      end
      tick();
      checks++;
      if (we_3 !== m3_we || w1_3 !== m3_w1 || d1_3 !== m3_d1) begin
        errors++; $display("FAIL rand_write cyc%0d: got we=%b w1=%h d1=%h want %b %h %h", i, we_3, w1_3, d1_3, m3_we, m3_w1, m3_d1);
      end
      if (w >= 0) valid3[w] = 1'b0;
    end
    arstn = 1; stall3 = 0; valid3 = 3'b000;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    for (int r = 0; r < 2; r++) begin addr2[r] = '0; data2[r] = '0; end
    for (int r = 0; r < 3; r++) begin addr3[r] = '0; data3[r] = '0; end
    m2_ptr = 1; m3_ptr = 2;
    m2_we = 0; mnd_we = 0; m3_we = 0;
    m2_w1 = 0; m2_d1 = 0; m3_w1 = 0; m3_d1 = 0;
    @(negedge clk);
    test_reset();
    test_single();
    test_contention();
    test_stall();
    test_r0_drop();
    test_reset_mid();
    test_fairness();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single write port (inW1/inD1/inWe) of the 32x32 register file between NREQ writeback requesters, e.g. the ALU result path and the load path.
- Each requester uses a valid/ready handshake. Arbitration is round-robin.
- The winning write is registered and presented to the register file one cycle later.
- Sits between the execute/memory stages and the register block; the register file's read ports are untouched.

Parameters:
- NREQ, 2, number of requesters (2..8)
- DROP_R0, 1, if 1, accepted writes to address 0 are consumed but never issued (outWe stays 0)

Ports:
- inClk  input  1  clock, all logic on rising edge
- inArstn  input  1  reset, synchronous and active-low
- inStall  input  1  when 1, no grant this cycle
- inReqValid  input  NREQ  per-requester write request
- inReqAddr  input  NREQ*5  flattened destination addresses; requester i uses bits [5i+4:5i]
- inReqData  input  NREQ*32  flattened write data; requester i uses bits [32i+31:32i]
- outReqReady  output  NREQ  one-hot grant (combinational); transfer when valid&ready at clock edge
- outW1  output  5  register file write address (registered)
- outD1  output  32  register file write data (registered)
- outWe  output  1  register file write enable (registered)

Behaviour:
- Reset (inArstn=0 sampled at posedge):
  - outWe=0, outW1=0, outD1=0.
  - Round-robin pointer lastGnt = NREQ-1, so requester 0 has first priority.
  - While inArstn=0, outReqReady is forced to all zeros.
- Grant (combinational):
  - If inArstn=1 and inStall=0, search inReqValid starting at index (lastGnt+1) mod NREQ, wrapping.
  - The first set bit wins; outReqReady is one-hot on the winner.
  - No valid request, or stall, gives outReqReady=0.
  - Ready never depends on the winner's own data or address.
- Transfer at posedge when any valid&ready:
  - lastGnt <= winner index.
  - outW1 <= winner address, outD1 <= winner data.
  - outWe <= 1, except outWe <= 0 when DROP_R0=1 and the address is 0.
- No transfer at posedge: outWe <= 0; outW1/outD1 hold their last values; lastGnt holds.
- Timing:
  - Latency from accepting edge to outWe high is 1 cycle.
  - Throughput is 1 write per cycle.
  - The register file captures the write on the following edge.
- Fairness: with k requesters continuously valid, each is granted exactly once every k cycles. A single active requester is granted every cycle.
- Requester rule: a requester keeps valid/addr/data stable until it sees ready. The arbiter does not latch unaccepted requests, and a dropped valid is simply skipped.
- Simultaneous stall and valid: stall wins; no grant, no pointer change, and next-cycle outWe=0.
- Reset mid-operation: a write registered in the same edge as reset is discarded, and outWe=0 in the following cycle. Requests pending during reset are not granted and must be re-presented.
- Wrap-around: the pointer moves from NREQ-1 to 0 via modulo, with no invalid index for any legal NREQ.
- No X on outputs after the first reset edge.

Decomposition:
- Package rf_pkg holds:
  - RF_ADDR_W=5, RF_DATA_W=32, RF_DEPTH=32
  - a helper function that extracts requester i's address/data slice
- Sub-module rr_arbiter (parameter N) contains the combinational rotate/priority search and returns onehot grant plus index. The lastGnt register stays in rf_write_arbiter.

Test Plan:
- Reset: hold inArstn=0 for 3 cycles with all requesters valid -> outReqReady=00 and outWe=0 throughout. After release, requester 0 is granted first.
- Single requester: req1 valid, addr 5'd7, data 32'hbadb0007 -> ready[1]=1 in the same cycle. The next cycle shows outWe=1, outW1=7, outD1=32'hbadb0007, and the register file read of addr 7 returns 32'hbadb0007 after the write edge.
- Contention, NREQ=2, both valid for 6 cycles -> grants alternate 0,1,0,1,0,1 and outWe stays 1 for 6 consecutive cycles.
- Stall: both valid with inStall=1 for 2 cycles -> no ready, outWe=0, and the pointer is unchanged, so the grant order resumes where it left off.
- R0 drop: DROP_R0=1, req0 writes addr 0 with data 32'hffffffff -> ready[0]=1 but outWe=0 next cycle, and register 0 is unchanged. With DROP_R0=0 -> outWe=1.
- Reset mid-stream: both requesters streaming, then assert inArstn=0 for 1 cycle -> outWe=0 the next cycle and requester 0 is granted first after release.
